// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared helpers for the out-of-order core front end.
//   count_width(depth) : bits needed to hold an occupancy value 0..depth.
// ----------------------------------------------------------------------------
package core_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_fifo_slot.sv
// ----------------------------------------------------------------------------
// shift_fifo_slot
// One storage slot of the collapsing shift FIFO: a BITWIDTH register that
// either holds, loads its upper neighbour (shift on pop) or loads the
// producer's entry (push). Clear wins over everything, then input, then
// neighbour, so a push+pop cycle lands in_data on top of the shift.
//
// Ports:
//   clk          clock, rising edge
//   clear        synchronous clear (reset or flush)
//   sel_input    load din
//   sel_neighbor load neighbor (slot above)
//   neighbor     contents of slot i+1 (0 for the top slot)
//   din          entry offered by the producer
//   q            registered slot contents
// ----------------------------------------------------------------------------
module shift_fifo_slot #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                sel_input,
    input  logic                sel_neighbor,
    input  logic [BITWIDTH-1:0] neighbor,
    input  logic [BITWIDTH-1:0] din,
    output logic [BITWIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (sel_input) begin
            q <= din;
        end else if (sel_neighbor) begin
            q <= neighbor;
        end
    end

endmodule

// File: rtl/shift_fifo.sv
// ----------------------------------------------------------------------------
// shift_fifo
// Collapsing shift-register FIFO between decode/rename and dispatch. Slot 0
// always holds the oldest entry and drives out_data straight from a register;
// a pop shifts every slot down by one, a push writes the first free slot.
// Dead slots are kept at zero so out_data reads 0 whenever empty.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (push = in_valid & in_ready, pop = out_valid & out_ready).
// in_ready and out_valid depend only on the registered count, never on the
// other side's valid/ready, so a full buffer refuses a push even while
// popping. A flush or reset in the same cycle squashes both transfers.
//
// Parameters: BITWIDTH entry width, DEPTH slot count (>= 2).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               discard all entries
//   in_data/in_valid    producer side, in_ready = (count < DEPTH)
//   out_data/out_valid  consumer side (slot 0), out_valid = (count != 0)
//   out_ready           consumer takes slot 0
//   count, full, empty  occupancy status
// ----------------------------------------------------------------------------
module shift_fifo
    import core_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [BITWIDTH-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [BITWIDTH-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int CW = count_width(DEPTH);

    logic                clear;
    logic                push;
    logic                pop;
    logic [BITWIDTH-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0]    at_count;     // one-hot: count == i
    logic [DEPTH-1:0]    at_count_m1;  // one-hot: count == i+1
    logic [DEPTH-1:0]    sel_in;

    assign clear     = reset | flush;
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = slot_q[0];

    // With a simultaneous pop the whole array moves down one, so the free
    // slot the new entry must land in is count-1 instead of count.
    always_comb begin
        at_count    = '0;
        at_count_m1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            at_count[i]    = (count == CW'(i));
            at_count_m1[i] = (count == CW'(i + 1));
        end
        sel_in = '0;
        if (push) begin
            sel_in = pop ? at_count_m1 : at_count;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [BITWIDTH-1:0] nb;
        if (i == DEPTH - 1) begin : g_top
            assign nb = '0;
        end else begin : g_mid
            assign nb = slot_q[i+1];
        end

        shift_fifo_slot #(
            .BITWIDTH(BITWIDTH)
        ) u_slot (
            .clk         (clk),
            .clear       (clear),
            .sel_input   (sel_in[i]),
            .sel_neighbor(pop),
            .neighbor    (nb),
            .din         (in_data),
            .q           (slot_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Occupancy invariants guaranteed by the handshake rules.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= CW'(DEPTH));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: tb/tb_shift_fifo.sv
// ----------------------------------------------------------------------------
// tb_shift_fifo
// Self-checking bench for shift_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_shift_fifo;

    localparam int BITWIDTH = 32;
    localparam int DEPTH    = 8;

    logic                clk;
    logic                reset;
    logic                flush;
    logic [BITWIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          count;
    logic                full;
    logic                empty;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: the live entries, oldest first.
    logic [BITWIDTH-1:0] exp_q [$];

    shift_fifo #(
        .BITWIDTH(BITWIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"},     32'(count),     32'(n));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
        check({tag, ".full"},      32'(full),      32'(n == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(n == 0));
        check({tag, ".out_data"},  out_data,       (n != 0) ? exp_q[0] : 32'h0);
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of inputs, advance the model by the handshake rules,
    // then compare every output just after the edge.
    task automatic cyc(input string tag, input logic v, input logic [31:0] d,
                       input logic r, input logic f, input logic rst);
        int  n;
        bit  do_push, do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        reset     = rst;
        n       = exp_q.size();
        do_push = v && (n < DEPTH);
        do_pop  = r && (n > 0);
        @(posedge clk);
        #1;
        if (rst || f) begin
            exp_q.delete();
        end else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
        end
        check_outputs(tag);
    endtask

    task automatic push_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cyc("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Three pushes, then drain in order
        cyc("pushA1", 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
        cyc("pushB2", 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
        cyc("pushC3", 1'b1, 32'hC3, 1'b0, 1'b0, 1'b0);
        check("three_count", 32'(count), 32'd3);
        check("three_head", out_data, 32'hA1);
        check("pop_A1", out_data, 32'hA1);
        cyc("pop1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("pop_B2", out_data, 32'hB2);
        cyc("pop2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("pop_C3", out_data, 32'hC3);
        cyc("pop3", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drained_empty", 32'(empty), 32'd1);
        check("drained_data", out_data, 32'h0);

        // Fill, then push+pop while full: only the pop happens
        push_n("fill", DEPTH);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        cyc("full_pushpop", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd7);

        // count==1: push+pop lands the new entry directly in slot 0
        cyc("flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc("push11", 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc("pp22", 1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        check("pp22_count", 32'(count), 32'd1);
        check("pp22_data", out_data, 32'h22);

        // Steady-state push+pop at count 4 for 20 cycles
        push_n("to4", 3);
        for (int i = 0; i < 20; i++) cyc("stream4", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        check("stream4_count", 32'(count), 32'd4);

        // Flush with a push offered at count 5
        push_n("to5", 1);
        cyc("flush5", 1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0);
        check("flush5_count", 32'(count), 32'd0);
        check("flush5_data", out_data, 32'h0);
        cyc("after_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream at count 6, then a push is visible next cycle
        push_n("to6", 6);
        cyc("rst6", 1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        check("rst6_count", 32'(count), 32'd0);
        cyc("post_rst_push", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        check("post_rst_data", out_data, 32'h1234_5678);

        // Random traffic with occasional flush/reset
        for (int i = 0; i < 2000; i++) begin
            cyc("rand",
                1'($urandom_range(0, 3) != 0),
                $urandom,
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
